// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection, writeback data, and the misaligned-target trap.
// Each advance either retires an instruction or raises a trap that holds until trap_ack.
module pc_sequencer #(
   parameter int XLEN   = 64,
   parameter int PCW    = 32,
   parameter int NFLAGS = 8,
   parameter logic [PCW-1:0] RESET_VECTOR = '0,
   parameter logic [PCW-1:0] TRAP_VECTOR  = PCW'(32'h100),
   localparam int FW = (NFLAGS > 1) ? $clog2(NFLAGS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              advance,
   input  logic [NFLAGS-1:0] flags,
   input  logic [FW-1:0]     sel_flag,
   input  logic              branch,
   input  logic              jal,
   input  logic              jalr,
   input  logic              auipc,
   input  logic [PCW-1:0]    imm,
   input  logic [XLEN-1:0]   rs1,
   input  logic [XLEN-1:0]   alu_out,
   input  logic [XLEN-1:0]   mem_data,
   input  logic [1:0]        sel_rf,
   input  logic              trap_ack,
   output logic [PCW-1:0]    pc,
   output logic [XLEN-1:0]   rf_din,
   output logic              rf_we,
   output logic              redirect,
   output logic              trap,
   output logic [15:0]       taken_cnt,
   output logic              fsm_state
);

   typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

   state_t          state, state_n;
   logic [PCW-1:0]  pc_n;
   logic [XLEN-1:0] rf_din_n;
   logic            rf_we_n;
   logic            redirect_n;
   logic [15:0]     cnt_n;

   logic            taken;
   logic            non_seq;
   logic [PCW-1:0]  jalr_sum;
   logic [PCW-1:0]  target;
   logic [XLEN-1:0] pc_x;
   logic [XLEN-1:0] imm_x;
   logic [XLEN-1:0] link_val;
   logic [XLEN-1:0] wb_val;
   logic            unused_rs1;

   assign unused_rs1 = ^rs1[XLEN-1:PCW];

   // An out-of-range flag index reads as "condition false".
   assign taken   = branch && (int'(sel_flag) < NFLAGS) && flags[sel_flag];
   assign non_seq = jal || jalr || taken;

   assign jalr_sum = rs1[PCW-1:0] + imm;
   assign pc_x     = XLEN'(signed'(pc));
   assign imm_x    = XLEN'(signed'(imm));

   always_comb begin
      target = pc + PCW'(4);
      if (jalr)
         target = jalr_sum & ~PCW'(1);
      else if (jal || taken)
         target = pc + imm;
   end

   always_comb begin
      link_val = pc_x + imm_x;
      if (jal || jalr)
         link_val = pc_x + XLEN'(4);
   end

   always_comb begin
      wb_val = alu_out;
      case (sel_rf)
         2'd1:    wb_val = mem_data;
         2'd3:    wb_val = link_val;
         default: wb_val = alu_out;
      endcase
   end

   // Handshake: advance is a one-cycle retire strobe accepted only in RUN;
   // trap_ack is accepted only in TRAP. Neither input is ever back-pressured.
   always_comb begin
      state_n    = state;
      pc_n       = pc;
      rf_din_n   = rf_din;
      rf_we_n    = 1'b0;
      redirect_n = 1'b0;
      cnt_n      = taken_cnt;
      case (state)
         RUN: begin
            if (advance) begin
               if (non_seq && (target[1:0] != 2'b00)) begin
                  state_n = TRAP;
               end else begin
                  pc_n     = target;
                  rf_din_n = wb_val;
                  rf_we_n  = 1'b1;
                  if (non_seq) begin
                     redirect_n = 1'b1;
                     cnt_n      = taken_cnt + 16'd1;
                  end
               end
            end
         end
         TRAP: begin
            if (trap_ack) begin
               state_n    = RUN;
               pc_n       = TRAP_VECTOR;
               redirect_n = 1'b1;
            end
         end
         default: state_n = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         pc        <= RESET_VECTOR;
         rf_din    <= '0;
         rf_we     <= 1'b0;
         redirect  <= 1'b0;
         taken_cnt <= '0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         rf_din    <= rf_din_n;
         rf_we     <= rf_we_n;
         redirect  <= redirect_n;
         taken_cnt <= cnt_n;
      end
   end

   assign trap      = (state == TRAP);
   assign fsm_state = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential flow, branches, jumps, trap entry/exit,
// PC wrap and asynchronous reset during a trap.
`timescale 1ns/1ps
module tb_pc_sequencer;

   logic        clk;
   logic        rst_n;
   logic        advance;
   logic [7:0]  flags;
   logic [2:0]  sel_flag;
   logic        branch, jal, jalr, auipc;
   logic [31:0] imm;
   logic [63:0] rs1, alu_out, mem_data;
   logic [1:0]  sel_rf;
   logic        trap_ack;
   logic [31:0] pc;
   logic [63:0] rf_din;
   logic        rf_we, redirect, trap;
   logic [15:0] taken_cnt;
   logic        fsm_state;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_q[$];

   pc_sequencer dut (
      .clk(clk), .rst_n(rst_n), .advance(advance), .flags(flags), .sel_flag(sel_flag),
      .branch(branch), .jal(jal), .jalr(jalr), .auipc(auipc), .imm(imm), .rs1(rs1),
      .alu_out(alu_out), .mem_data(mem_data), .sel_rf(sel_rf), .trap_ack(trap_ack),
      .pc(pc), .rf_din(rf_din), .rf_we(rf_we), .redirect(redirect), .trap(trap),
      .taken_cnt(taken_cnt), .fsm_state(fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic adv, input logic br, input logic jl, input logic jr,
                         input logic au, input logic ack, input logic [31:0] im,
                         input logic [1:0] sr);
      advance  = adv;
      branch   = br;
      jal      = jl;
      jalr     = jr;
      auipc    = au;
      trap_ack = ack;
      imm      = im;
      sel_rf   = sr;
   endtask

   task automatic drive(input logic adv, input logic br, input logic jl, input logic jr,
                        input logic au, input logic ack, input logic [31:0] im,
                        input logic [1:0] sr);
      @(negedge clk);
      set_in(adv, br, jl, jr, au, ack, im, sr);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_pc"},       64'(pc),        64'h0);
      check({tag, "_rf_din"},   rf_din,         64'h0);
      check({tag, "_rf_we"},    64'(rf_we),     64'h0);
      check({tag, "_redirect"}, 64'(redirect),  64'h0);
      check({tag, "_trap"},     64'(trap),      64'h0);
      check({tag, "_cnt"},      64'(taken_cnt), 64'h0);
      check({tag, "_state"},    64'(fsm_state), 64'h0);
   endtask

   initial begin
      rst_n    = 1'b0;
      flags    = 8'h00;
      sel_flag = 3'd0;
      rs1      = 64'h0;
      alu_out  = 64'h0000_0000_0000_A5A5;
      mem_data = 64'h0000_0000_0000_5A5A;
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
      #3;
      check_reset("reset");

      // sequential flow; first advance takes effect on the first edge after release
      @(negedge clk);
      rst_n = 1'b1;
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      exp_q.push_back(32'hC);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
         tick();
         check("seq_pc", 64'(pc), 64'(exp_q.pop_front()));
         check("seq_we", 64'(rf_we), 64'h1);
         check("seq_redirect", 64'(redirect), 64'h0);
         check("seq_rf_din", rf_din, 64'hA5A5);
      end

      // idle cycle with a stray trap_ack in RUN
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 2'd0);
      tick();
      check("idle_pc", 64'(pc), 64'hC);
      check("idle_we", 64'(rf_we), 64'h0);
      check("idle_trap", 64'(trap), 64'h0);
      check("idle_redirect", 64'(redirect), 64'h0);

      // jal to 0x40 with link writeback
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h34, 2'd3);
      tick();
      check("jal_pc", 64'(pc), 64'h40);
      check("jal_link", rf_din, 64'h10);
      check("jal_redirect", 64'(redirect), 64'h1);
      check("jal_cnt", 64'(taken_cnt), 64'd1);

      // taken branch backwards, mem_data writeback
      flags    = 8'h08;
      sel_flag = 3'd3;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 2'd1);
      tick();
      check("br_taken_pc", 64'(pc), 64'h38);
      check("br_taken_rf_din", rf_din, 64'h5A5A);
      check("br_taken_redirect", 64'(redirect), 64'h1);
      check("br_taken_cnt", 64'(taken_cnt), 64'd2);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
      tick();
      check("redirect_pulse", 64'(redirect), 64'h0);

      // back to 0x40, then untaken branch falls through
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 2'd0);
      tick();
      check("jal2_pc", 64'(pc), 64'h40);
      flags = 8'hF7;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 2'd0);
      tick();
      check("br_not_pc", 64'(pc), 64'h44);
      check("br_not_redirect", 64'(redirect), 64'h0);
      check("br_not_cnt", 64'(taken_cnt), 64'd3);

      // jalr from 0x10 with upper rs1 garbage and odd target
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFCC, 2'd0);
      tick();
      check("jal3_pc", 64'(pc), 64'h10);
      rs1 = 64'hDEAD_0000_0000_2001;
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4, 2'd3);
      tick();
      check("jalr_pc", 64'(pc), 64'h2004);
      check("jalr_link", rf_din, 64'h14);
      check("jalr_we", 64'(rf_we), 64'h1);
      check("jalr_cnt", 64'(taken_cnt), 64'd5);

      // misaligned jal from 0x20 traps
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_E01C, 2'd0);
      tick();
      check("jal4_pc", 64'(pc), 64'h20);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h6, 2'd3);
      tick();
      check("trap_set", 64'(trap), 64'h1);
      check("trap_pc", 64'(pc), 64'h20);
      check("trap_we", 64'(rf_we), 64'h0);
      check("trap_redirect", 64'(redirect), 64'h0);
      check("trap_cnt", 64'(taken_cnt), 64'd6);
      check("trap_state", 64'(fsm_state), 64'h1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
      tick();
      check("trap_hold_pc", 64'(pc), 64'h20);
      check("trap_hold", 64'(trap), 64'h1);
      check("trap_hold_we", 64'(rf_we), 64'h0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 2'd0);
      tick();
      check("ack_pc", 64'(pc), 64'h100);
      check("ack_trap", 64'(trap), 64'h0);
      check("ack_redirect", 64'(redirect), 64'h1);
      check("ack_cnt", 64'(taken_cnt), 64'd6);
      check("ack_state", 64'(fsm_state), 64'h0);

      // wrap: jump to 0xFFFFFFFC, then auipc with negative immediate
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FEFC, 2'd0);
      tick();
      check("wrapjal_pc", 64'(pc), 64'hFFFF_FFFC);
      check("wrapjal_cnt", 64'(taken_cnt), 64'd7);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 2'd3);
      tick();
      check("auipc_rf_din", rf_din, 64'hFFFF_FFFF_FFFF_FFF8);
      check("wrap_pc", 64'(pc), 64'h0);
      check("wrap_trap", 64'(trap), 64'h0);
      check("wrap_redirect", 64'(redirect), 64'h0);

      // enter trap again, then reset asynchronously between edges
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2, 2'd0);
      tick();
      check("trap2_set", 64'(trap), 64'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("async_reset");

      @(negedge clk);
      rst_n = 1'b1;
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
      tick();
      check("post_reset_pc", 64'(pc), 64'h4);
      check("post_reset_we", 64'(rf_we), 64'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter XLEN, default 64, register-file datapath width.
REQ-002 Parameter PCW, default 32, PC width; PCW <= XLEN.
REQ-003 Parameter NFLAGS, default 8, number of branch-condition flags; FW = clog2(NFLAGS).
REQ-004 Parameter RESET_VECTOR, default 0, PC loaded on reset.
REQ-005 Parameter TRAP_VECTOR, default 32'h100, PC loaded on trap acknowledge.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 advance  in  1  current instruction retires this cycle; PC updates.
REQ-010 flags  in  NFLAGS  ALU condition flags.
REQ-011 sel_flag  in  FW  flag index used for branch decision.
REQ-012 branch / jal / jalr / auipc  in  1 each  instruction-class strobes.
REQ-013 imm  in  PCW  signed immediate.
REQ-014 rs1  in  XLEN  register-file port A data.
REQ-015 alu_out, mem_data  in  XLEN each  writeback sources.
REQ-016 sel_rf  in  2  writeback select.
REQ-017 trap_ack  in  1  handler accepts pending misalignment trap.
REQ-018 pc  out  PCW  registered program counter.
REQ-019 rf_din  out  XLEN  registered writeback data.
REQ-020 rf_we  out  1  registered writeback strobe.
REQ-021 redirect  out  1  one-cycle pulse, PC changed non-sequentially.
REQ-022 trap  out  1  level, misaligned target pending.
REQ-023 taken_cnt  out  16  count of redirects since reset, wraps 16'hFFFF -> 0.

Function
REQ-024 FSM states RUN and TRAP; reset enters RUN.
REQ-025 Arithmetic in XLEN after sign-extending pc and imm from bit PCW-1; target truncated to PCW.
REQ-026 Branch decision: taken = branch & flags[sel_flag]; sel_flag >= NFLAGS -> not taken.
REQ-027 Target priority: jalr -> (rs1[PCW-1:0]+imm) with bit0 cleared; else jal or taken -> pc+imm; else pc+4.
REQ-028 Link value = sext(pc)+4 for jal/jalr; AUIPC value = sext(pc)+sext(imm).
REQ-029 rf_din mux: 0 alu_out, 1 mem_data, 2 alu_out, 3 link/AUIPC value (jal/jalr win over auipc).
REQ-030 RUN, advance=1, target[1:0]==0: pc <= target next edge, latency 1 cycle.
REQ-031 Same cycle: rf_din <= selected value, rf_we <= 1; rf_we low in any cycle without accepted advance.
REQ-032 redirect <= 1 and taken_cnt increments for accepted jal, jalr or taken branch only.
REQ-033 RUN, advance=1, non-sequential target[1:0]!=0: pc unchanged, rf_we <= 0, state -> TRAP, trap <= 1.
REQ-034 TRAP: advance ignored; trap held high; pc held.
REQ-035 TRAP, trap_ack=1: pc <= TRAP_VECTOR, trap <= 0, state -> RUN, redirect <= 1, taken_cnt unchanged.
REQ-036 trap_ack in RUN ignored.
REQ-037 advance=0: all state held, rf_we=0, redirect=0.
REQ-038 Wrap-around: pc+4 or pc+imm overflowing PCW wraps modulo 2^PCW, no trap.

Reset
REQ-039 rst_n low, at any time incl. mid-TRAP: pc=RESET_VECTOR, rf_din=0, rf_we=0, redirect=0, trap=0, taken_cnt=0, state RUN, immediately.
REQ-040 First advance honoured on first rising edge after rst_n deasserts.

Verification
REQ-041 Reset then advance x3, no strobes -> pc 0,4,8,12; redirect 0; rf_we 1 each cycle.
REQ-042 pc=0x40, branch=1, flags[3]=1, sel_flag=3, imm=-8 -> pc=0x38, redirect pulse, taken_cnt=1; flags[3]=0 -> pc=0x44.
REQ-043 pc=0x10, jalr=1, rs1=0x2001, imm=4, sel_rf=3 -> pc=0x2004, rf_din=0x14, rf_we=1.
REQ-044 pc=0x20, jal=1, imm=6 -> trap=1, pc stays 0x20, advance ignored; trap_ack -> pc=0x100, trap=0.
REQ-045 pc=0xFFFFFFFC (PCW=32), auipc=1, imm=-4, sel_rf=3 -> rf_din=0xFFFFFFFF_FFFFFFF8, pc=0x0.
REQ-046 rst_n pulled low while trap=1 -> all outputs at reset values without clock edge.
